move_select: RTL



---
 rtl/move_select.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/move_select.sv
// move_select: picks a winning, blocking or first-free move for the side to play.
// Build option: define MOVE_SELECT_BLOCK_EN to include the opponent-blocking pass.
module move_select #(
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 3,
  parameter int unsigned WIN  = 3,
  localparam int unsigned N   = ROWS * COLS,
  localparam int unsigned PW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ready,
  input  logic          target_a,
  input  logic [N-1:0]  board_a,
  input  logic [N-1:0]  board_b,
  output logic [N-1:0]  board_a_out,
  output logic [N-1:0]  board_b_out,
  output logic [PW-1:0] move_idx,
  output logic          valid,
  output logic          error
);

  typedef enum logic [2:0] {
    StIdle,
    StScanWin,
    StScanBlock,
    StScanFree,
    StEmit
  } state_e;

  localparam logic [PW-1:0] LastPt = PW'(N - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pt_q, pt_d;
  logic          busy_q, busy_d;
  logic          none_q, none_d;
  logic          tgt_q, tgt_d;
  logic [N-1:0]  cap_a_q, cap_a_d;
  logic [N-1:0]  cap_b_q, cap_b_d;
  logic [N-1:0]  out_a_q, out_a_d;
  logic [N-1:0]  out_b_q, out_b_d;
  logic [PW-1:0] move_q, move_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  logic [N-1:0]  own_b, free_b, win_vec, pick_mask;

  // True when marks, plus a mark at idx, hold WIN in a row through idx along any axis.
  function automatic logic completes_line(input logic [N-1:0] marks, input int idx);
    int r, c, dr, dc, rr, cc, cnt;
    logic run, hit;
    logic [N-1:0] sh;
    hit = 1'b0;
    r = idx / int'(COLS);
    c = idx % int'(COLS);
    for (int d = 0; d < 4; d++) begin
      dr  = (d == 0) ? 0 : 1;
      dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      cnt = 1;
      for (int dir = -1; dir <= 1; dir += 2) begin
        run = 1'b1;
        for (int k = 1; k < int'(WIN); k++) begin
          rr = r + dir * k * dr;
          cc = c + dir * k * dc;
          if (run && rr >= 0 && rr < int'(ROWS) && cc >= 0 && cc < int'(COLS)) begin
            sh = marks >> (rr * int'(COLS) + cc);
            if (sh[0]) cnt++;
            else run = 1'b0;
          end else begin
            run = 1'b0;
          end
        end
      end
      if (cnt >= int'(WIN)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    own_b  = tgt_q ? cap_a_q : cap_b_q;
    free_b = ~(cap_a_q | cap_b_q);
    for (int i = 0; i < int'(N); i++) begin
      win_vec[i] = free_b[i] & completes_line(own_b, i);
    end
  end

`ifdef MOVE_SELECT_BLOCK_EN
  logic [N-1:0] opp_b, blk_vec;

  always_comb begin
    opp_b = tgt_q ? cap_b_q : cap_a_q;
    for (int i = 0; i < int'(N); i++) begin
      blk_vec[i] = free_b[i] & completes_line(opp_b, i);
    end
  end
`endif

  assign pick_mask = {{(N-1){1'b0}}, 1'b1} << pt_q;

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    busy_d  = busy_q;
    none_d  = none_q;
    tgt_d   = tgt_q;
    cap_a_d = cap_a_q;
    cap_b_d = cap_b_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    move_d  = move_q;
    error_d = error_q;
    valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          cap_a_d = board_a;
          cap_b_d = board_b;
          tgt_d   = target_a;
          busy_d  = 1'b1;
          pt_d    = '0;
          none_d  = 1'b0;
          state_d = StScanWin;
        end
      end
      StScanWin: begin
        if (win_vec[pt_q]) begin
          state_d = StEmit;
        end else if (pt_q == LastPt) begin
          pt_d = '0;
`ifdef MOVE_SELECT_BLOCK_EN
          state_d = StScanBlock;
`else
          state_d = StScanFree;
`endif
        end else begin
          pt_d = pt_q + PW'(1);
        end
      end
`ifdef MOVE_SELECT_BLOCK_EN
      StScanBlock: begin
        if (blk_vec[pt_q]) begin
          state_d = StEmit;
        end else if (pt_q == LastPt) begin
          pt_d    = '0;
          state_d = StScanFree;
        end else begin
          pt_d = pt_q + PW'(1);
        end
      end
`endif
      StScanFree: begin
        if (free_b[pt_q]) begin
          state_d = StEmit;
        end else if (pt_q == LastPt) begin
          none_d  = 1'b1;
          state_d = StEmit;
        end else begin
          pt_d = pt_q + PW'(1);
        end
      end
      StEmit: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        error_d = none_q;
        state_d = StIdle;
        if (none_q) begin
          move_d  = '0;
          out_a_d = cap_a_q;
          out_b_d = cap_b_q;
        end else begin
          move_d  = pt_q;
          out_a_d = cap_a_q | (tgt_q ? pick_mask : '0);
          out_b_d = cap_b_q | (tgt_q ? '0 : pick_mask);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      none_q  <= 1'b0;
      tgt_q   <= 1'b0;
      cap_a_q <= '0;
      cap_b_q <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      move_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      busy_q  <= busy_d;
      none_q  <= none_d;
      tgt_q   <= tgt_d;
      cap_a_q <= cap_a_d;
      cap_b_q <= cap_b_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      move_q  <= move_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign ready       = ~req & ~busy_q;
  assign board_a_out = out_a_q;
  assign board_b_out = out_b_q;
  assign move_idx    = move_q;
  assign valid       = valid_q;
  assign error       = error_q;

endmodule
